// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, mode codes, flag indices and multiplier states for alu_seq
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [1:0] MODE_DP    = 2'b00;
    localparam logic [1:0] MODE_MUL   = 2'b01;
    localparam logic [1:0] MODE_UMULL = 2'b10;
    localparam logic [1:0] MODE_SMULL = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

    // TST, TEQ, CMP and CMN occupy opcodes 8..11.
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - radix-2 shift-add WIDTH x WIDTH multiplier, one bit per cycle
// Ports: clk, rst_n (async low), flush (abort), start (load operands, begin WIDTH iterations),
//        is_signed (two's complement operands), a/b (operands), acc (added to the 2W product),
//        busy (iterating), done (final iteration this cycle; prod_* valid this cycle only),
//        prod_hi/prod_lo (final product, combinational while done).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int W2 = 2 * WIDTH;

    mul_state_t       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand, hi, lo, acc_r;
    logic             neg;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic [W2-1:0]    full, fin;

    // Signed operands are multiplied as magnitudes; the most negative value's
    // magnitude still fits unsigned in WIDTH bits.
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // The multiplier sits in lo and is shifted out as product bits shift in.
    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign nxt_hi = sum[WIDTH:1];
    assign nxt_lo = {sum[0], lo[WIDTH-1:1]};
    assign full   = {nxt_hi, nxt_lo};

    // Sign fix-up and accumulate are folded into the last iteration.
    assign fin     = (neg ? (~full + W2'(1)) : full) + {{WIDTH{1'b0}}, acc_r};
    assign prod_hi = fin[W2-1:WIDTH];
    assign prod_lo = fin[WIDTH-1:0];

    assign busy = (state == MUL_RUN);
    assign done = busy && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = MUL_IDLE;
        end else begin
            case (state)
                MUL_IDLE: if (start) state_n = MUL_RUN;
                MUL_RUN:  if (done)  state_n = MUL_IDLE;
                default:  state_n = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            acc_r <= '0;
            neg   <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start && !busy) begin
            cnt   <= '0;
            mcand <= a_mag;
            hi    <= '0;
            lo    <= b_mag;
            acc_r <= acc;
            neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (busy) begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ARMv4 ALU with NZCV register and iterative multiplier
// Ports: clk, rst_n (async low), flush; input side in_valid/in_ready with in_mode, in_op,
//        in_acc, in_s, in_a, in_b, in_c, in_sh_carry; output side out_valid/out_ready with
//        out_lo, out_hi, out_wr, out_wr_hi; nzcv flag register; busy while multiplying.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [3:0]       in_op,
    input  logic             in_acc,
    input  logic             in_s,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_sh_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_wr,
    output logic             out_wr_hi,
    output logic [3:0]       nzcv,
    output logic             busy
);

    logic             accept, accept_dp, mul_start, mul_done;
    logic [WIDTH-1:0] mul_hi, mul_lo, mul_acc;
    logic             mul_long, mul_s;

    logic [WIDTH-1:0] dp_res, add_x, add_y;
    logic             add_ci, arith, cmp_op;
    logic [WIDTH:0]   add_sum;
    logic [3:0]       dp_flags;

    assign in_ready  = !busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign accept_dp = accept && (in_mode == MODE_DP);
    assign mul_start = accept && (in_mode != MODE_DP);
    assign mul_acc   = (in_mode == MODE_MUL && in_acc) ? in_c : '0;

    alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .start     (mul_start),
        .is_signed (in_mode == MODE_SMULL),
        .a         (in_a),
        .b         (in_b),
        .acc       (mul_acc),
        .busy      (busy),
        .done      (mul_done),
        .prod_hi   (mul_hi),
        .prod_lo   (mul_lo)
    );

    // All arithmetic ops reduce to x + y + ci; subtraction inverts the
    // subtrahend so the carry-out is directly NOT borrow.
    always_comb begin
        add_x  = in_a;
        add_y  = in_b;
        add_ci = 1'b0;
        arith  = 1'b1;
        dp_res = '0;
        case (in_op)
            OP_SUB, OP_CMP: begin add_y = ~in_b; add_ci = 1'b1; end
            OP_RSB:         begin add_x = in_b; add_y = ~in_a; add_ci = 1'b1; end
            OP_ADD, OP_CMN: add_ci = 1'b0;
            OP_ADC:         add_ci = nzcv[FLAG_C];
            OP_SBC:         begin add_y = ~in_b; add_ci = nzcv[FLAG_C]; end
            OP_RSC:         begin add_x = in_b; add_y = ~in_a; add_ci = nzcv[FLAG_C]; end
            default:        arith = 1'b0;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
        case (in_op)
            OP_AND, OP_TST: dp_res = in_a & in_b;
            OP_EOR, OP_TEQ: dp_res = in_a ^ in_b;
            OP_ORR:         dp_res = in_a | in_b;
            OP_MOV:         dp_res = in_b;
            OP_BIC:         dp_res = in_a & ~in_b;
            OP_MVN:         dp_res = ~in_b;
            default:        dp_res = add_sum[WIDTH-1:0];
        endcase
        cmp_op           = is_compare(in_op);
        dp_flags[FLAG_N] = dp_res[WIDTH-1];
        dp_flags[FLAG_Z] = (dp_res == '0);
        dp_flags[FLAG_C] = arith ? add_sum[WIDTH] : in_sh_carry;
        dp_flags[FLAG_V] = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != add_x[WIDTH-1]))
                                 : nzcv[FLAG_V];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_lo    <= '0;
            out_hi    <= '0;
            out_wr    <= 1'b0;
            out_wr_hi <= 1'b0;
            nzcv      <= 4'b0000;
            mul_long  <= 1'b0;
            mul_s     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out_lo    <= mul_lo;
            out_hi    <= mul_long ? mul_hi : '0;
            out_wr    <= 1'b1;
            out_wr_hi <= mul_long;
            if (mul_s) begin
                nzcv[FLAG_N] <= mul_long ? mul_hi[WIDTH-1] : mul_lo[WIDTH-1];
                nzcv[FLAG_Z] <= mul_long ? ({mul_hi, mul_lo} == '0) : (mul_lo == '0);
            end
        end else if (accept_dp) begin
            out_valid <= 1'b1;
            out_lo    <= dp_res;
            out_hi    <= '0;
            out_wr    <= !cmp_op;
            out_wr_hi <= 1'b0;
            if (in_s || cmp_op) nzcv <= dp_flags;
        end else begin
            if (mul_start) begin
                mul_long <= in_mode[1];
                mul_s    <= in_s;
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_mode = 2'b00;
    logic [3:0]  in_op = 4'h0;
    logic        in_acc = 1'b0;
    logic        in_s = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] in_c = '0;
    logic        in_sh_carry = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_lo;
    logic [31:0] out_hi;
    logic        out_wr;
    logic        out_wr_hi;
    logic [3:0]  nzcv;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_op       (in_op),
        .in_acc      (in_acc),
        .in_s        (in_s),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .in_sh_carry (in_sh_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lo      (out_lo),
        .out_hi      (out_hi),
        .out_wr      (out_wr),
        .out_wr_hi   (out_wr_hi),
        .nzcv        (nzcv),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op; returns just after its accept edge.
    task automatic issue(input logic [1:0] mode, input logic [3:0] op, input logic acc,
                         input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic shc);
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) chk("issue_ready", 64'(in_ready), 64'd1);
        in_mode = mode; in_op = op; in_acc = acc; in_s = s;
        in_a = a; in_b = b; in_c = c; in_sh_carry = shc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output logic rdy_seen);
        cyc = 0;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (out_valid) begin
                cyc = k;
                break;
            end
            if (in_ready) rdy_seen = 1'b1;
        end
    endtask

    initial begin
        int   cyc;
        logic rdy;
        int   seen;

        #1;
        chk("rst_nzcv", 64'(nzcv), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_lo", 64'(out_lo), 64'd0);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        issue(2'b00, 4'h4, 0, 1, 32'h7FFF_FFFF, 32'h1, 0, 0);
        chk("adds_valid", 64'(out_valid), 64'd1);
        chk("adds_lo", 64'(out_lo), 64'h8000_0000);
        chk("adds_nzcv", 64'(nzcv), 64'h9);
        chk("adds_wr", 64'(out_wr), 64'd1);

        issue(2'b00, 4'h4, 0, 0, 32'h1, 32'h1, 0, 0);
        chk("add_lo", 64'(out_lo), 64'd2);
        chk("add_nzcv_held", 64'(nzcv), 64'h9);

        issue(2'b00, 4'hA, 0, 0, 32'd5, 32'd5, 0, 0);
        chk("cmp_wr", 64'(out_wr), 64'd0);
        chk("cmp_nzcv", 64'(nzcv), 64'h6);

        issue(2'b00, 4'h5, 0, 0, 32'd1, 32'd1, 0, 0);
        chk("adc_lo", 64'(out_lo), 64'd3);

        issue(2'b00, 4'h4, 0, 1, 32'd1, 32'd1, 0, 0);
        chk("adds_clr_nzcv", 64'(nzcv), 64'h0);

        issue(2'b00, 4'h6, 0, 1, 32'd0, 32'd1, 0, 0);
        chk("sbcs_lo", 64'(out_lo), 64'hFFFF_FFFE);
        chk("sbcs_nzcv", 64'(nzcv), 64'h8);

        issue(2'b00, 4'h3, 0, 1, 32'd1, 32'd3, 0, 0);
        chk("rsbs_lo", 64'(out_lo), 64'd2);
        chk("rsbs_nzcv", 64'(nzcv), 64'h2);

        issue(2'b00, 4'h4, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        chk("adds_ovf_lo", 64'(out_lo), 64'd0);
        chk("adds_ovf_nzcv", 64'(nzcv), 64'h7);

        issue(2'b10, 4'h0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("umull_busy", 64'(busy), 64'd1);
        wait_out(cyc, rdy);
        chk("umull_latency", 64'(cyc), 64'd32);
        chk("umull_ready_low", 64'(rdy), 64'd0);
        chk("umull_busy_done", 64'(busy), 64'd0);
        chk("umull_hi", 64'(out_hi), 64'hFFFF_FFFE);
        chk("umull_lo", 64'(out_lo), 64'h0000_0001);
        chk("umull_wr_hi", 64'(out_wr_hi), 64'd1);
        chk("umull_nzcv", 64'(nzcv), 64'hB);

        issue(2'b11, 4'h0, 0, 0, 32'hFFFF_FFFE, 32'd3, 0, 0);
        wait_out(cyc, rdy);
        chk("smull_hi", 64'(out_hi), 64'hFFFF_FFFF);
        chk("smull_lo", 64'(out_lo), 64'hFFFF_FFFA);
        chk("smull_nzcv", 64'(nzcv), 64'hB);

        issue(2'b01, 4'h0, 1, 1, 32'd3, 32'd4, 32'd5, 0);
        wait_out(cyc, rdy);
        chk("mla_lo", 64'(out_lo), 64'd17);
        chk("mla_hi", 64'(out_hi), 64'd0);
        chk("mla_wr_hi", 64'(out_wr_hi), 64'd0);
        chk("mla_nzcv", 64'(nzcv), 64'h3);

        issue(2'b01, 4'h0, 0, 0, 32'd6, 32'd7, 32'd99, 0);
        wait_out(cyc, rdy);
        chk("mul_noacc_lo", 64'(out_lo), 64'd42);

        step();
        out_ready = 1'b0;
        issue(2'b00, 4'h0, 0, 1, 32'h0000_F0F0, 32'h0000_FF00, 0, 0);
        in_mode = 2'b00; in_op = 4'h4; in_s = 1'b1; in_a = 32'd9; in_b = 32'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_lo", 64'(out_lo), 64'h0000_F000);
            chk("bp_nzcv", 64'(nzcv), 64'h1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        issue(2'b01, 4'h0, 0, 1, 32'd7, 32'd9, 0, 0);
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_nzcv", 64'(nzcv), 64'h1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        issue(2'b10, 4'h0, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #2;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_nzcv", 64'(nzcv), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        step();

        issue(2'b00, 4'h4, 0, 1, 32'd2, 32'd3, 0, 0);
        chk("post_rst_lo", 64'(out_lo), 64'd5);
        chk("post_rst_nzcv", 64'(nzcv), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
